// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SH_W register stages, stage k conditionally shifts by 2^k.
// A single enable stalls the whole pipe when the result register is full and not taken.

module pbs_shift #(
  parameter int WIDTH = 32,
  parameter int S     = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] q
);
  always_comb begin
    q = d;
    if (en) begin
      case (op)
        3'b000:  q = {d[WIDTH-1-S:0], {S{1'b0}}};
        3'b001:  q = {{S{1'b0}}, d[WIDTH-1:S]};
        // MSB is still the original sign: earlier SRA stages only ever replicate it
        3'b010:  q = {{S{d[WIDTH-1]}}, d[WIDTH-1:S]};
        3'b011:  q = {d[WIDTH-1-S:0], d[WIDTH-1:WIDTH-S]};
        3'b100:  q = {d[S-1:0], d[WIDTH-1:S]};
        default: q = d;
      endcase
    end
  end
endmodule

module pipelined_barrel_shifter #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SH_W-1:0]  in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [TAG_W-1:0] out_tag
);
  // Stage k only keeps the amount bits it and later stages still need, packed triangularly.
  localparam int AMT_BITS = SH_W * (SH_W + 1) / 2;

  function automatic int amt_off(input int k);
    return k * SH_W - (k * (k - 1)) / 2;
  endfunction

  logic                            advance;
  logic [SH_W:1]                   vld_pipe;
  logic [SH_W-1:0][WIDTH-1:0]      dat_q;
  logic [SH_W-1:0][WIDTH-1:0]      shf;
  logic [SH_W-1:0][2:0]            op_q;
  logic [SH_W-1:0][TAG_W-1:0]      tag_q;
  logic [AMT_BITS-1:0]             amt_q;

  assign out_valid = vld_pipe[SH_W];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_c     = shf[SH_W-1];
  assign out_tag   = tag_q[SH_W-1];

  always_ff @(posedge clk) begin
    if (rst)          vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[SH_W-1:1], in_valid};
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      dat_q[0]          <= in_a;
      op_q[0]           <= in_op;
      tag_q[0]          <= in_tag;
      amt_q[SH_W-1:0]   <= in_b;
      for (int k = 1; k < SH_W; k++) begin
        dat_q[k] <= shf[k-1];
        op_q[k]  <= op_q[k-1];
        tag_q[k] <= tag_q[k-1];
        for (int j = k; j < SH_W; j++)
          amt_q[amt_off(k) + j - k] <= amt_q[amt_off(k-1) + j - k + 1];
      end
    end
  end

  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    pbs_shift #(.WIDTH(WIDTH), .S(1 << k)) u_shift (
      .d  (dat_q[k]),
      .en (amt_q[amt_off(k)]),
      .op (op_q[k]),
      .q  (shf[k])
    );
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed scenarios on WIDTH=32 plus random
// scoreboard runs on WIDTH=8, 32 and 64 instances sharing one clock and reset.

module tb_pipelined_barrel_shifter;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_w  [3];
  logic       in_ready_w  [3];
  logic [63:0] in_a_w     [3];
  logic [5:0] in_b_w      [3];
  logic [2:0] in_op_w     [3];
  logic [3:0] in_tag_w    [3];
  logic       out_ready_w [3];
  logic       out_valid_w [3];
  logic [63:0] out_c_w    [3];
  logic [3:0] out_tag_w   [3];
  logic [7:0]  c8;
  logic [31:0] c32;
  logic [63:0] c64;
  int n_cmp, n_err;

  always #5 clk = ~clk;

  assign out_c_w[0] = {56'd0, c8};
  assign out_c_w[1] = {32'd0, c32};
  assign out_c_w[2] = c64;

  pipelined_barrel_shifter #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
    .in_a(in_a_w[0][7:0]), .in_b(in_b_w[0][2:0]), .in_op(in_op_w[0]), .in_tag(in_tag_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_w[0]), .out_c(c8), .out_tag(out_tag_w[0]));

  pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
    .in_a(in_a_w[1][31:0]), .in_b(in_b_w[1][4:0]), .in_op(in_op_w[1]), .in_tag(in_tag_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_w[1]), .out_c(c32), .out_tag(out_tag_w[1]));

  pipelined_barrel_shifter #(.WIDTH(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w[2]), .in_ready(in_ready_w[2]),
    .in_a(in_a_w[2]), .in_b(in_b_w[2]), .in_op(in_op_w[2]), .in_tag(in_tag_w[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready_w[2]), .out_c(c64), .out_tag(out_tag_w[2]));

  function automatic int wid(input int i);
    return (i == 0) ? 8 : (i == 1) ? 32 : 64;
  endfunction

  // Reference: whole-amount shifts on a masked 64-bit value.
  function automatic logic [63:0] model(input logic [63:0] a_in, input int b,
                                        input logic [2:0] op, input int w);
    logic [63:0] m, a, r;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a = a_in & m;
    case (op)
      3'd0:    r = (a << b) & m;
      3'd1:    r = a >> b;
      3'd2:    r = (a >> b) | (a[w-1] ? (m & ~(m >> b)) : 64'd0);
      3'd3:    r = ((a << b) | (a >> (w - b))) & m;
      3'd4:    r = ((a >> b) | (a << (w - b))) & m;
      default: r = a;
    endcase
    return r;
  endfunction

  task automatic put(input int i, input logic v, input logic [63:0] a, input int b,
                     input logic [2:0] op, input logic [3:0] tag);
    in_valid_w[i] = v;
    in_a_w[i]     = a;
    in_b_w[i]     = 6'(b);
    in_op_w[i]    = op;
    in_tag_w[i]   = tag;
  endtask

  task automatic test_reset;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_state inst%0d: out_valid=%b in_ready=%b, want 0/1", i, out_valid_w[i], in_ready_w[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid_w[1] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: out_valid=%b, want 0", out_valid_w[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    put(1, 1'b1, 64'h1, 31, 3'b000, 4'h3);
    @(negedge clk);
    n_cmp++;
    if (in_ready_w[1] !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: in_ready=%b, want 1", in_ready_w[1]);
    end
    @(posedge clk); #1;
    put(1, 1'b0, 64'h0, 0, 3'b000, 4'h0);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid_w[1] !== (t == 5)) begin
        n_err++;
        $display("FAIL single_latency cycle %0d: out_valid=%b, want %b", t, out_valid_w[1], (t == 5));
      end
      if (t == 5) begin
        n_cmp++;
        if (out_c_w[1] !== 64'h80000000 || out_tag_w[1] !== 4'h3) begin
          n_err++;
          $display("FAIL single_sll31: got %h/%h, want 80000000/3", out_c_w[1], out_tag_w[1]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a   [4] = '{32'h80000000, 32'h80000000, 32'h000000F1, 32'hF0000001};
    logic [2:0]  op  [4] = '{3'd2, 3'd1, 3'd4, 3'd3};
    logic [31:0] exp [4] = '{32'hF8000000, 32'h08000000, 32'h1000000F, 32'h0000001F};
    for (int t = 0; t < 11; t++) begin
      if (t < 4) put(1, 1'b1, {32'd0, a[t]}, 4, op[t], 4'(t + 8));
      else       put(1, 1'b0, 64'h0, 0, 3'd0, 4'h0);
      @(negedge clk);
      n_cmp++;
      if (out_valid_w[1] !== (t >= 5 && t <= 8)) begin
        n_err++;
        $display("FAIL b2b_valid cycle %0d: out_valid=%b, want %b", t, out_valid_w[1], (t >= 5 && t <= 8));
      end
      if (t >= 5 && t <= 8 && out_valid_w[1] === 1'b1) begin
        n_cmp++;
        if (out_c_w[1] !== {32'd0, exp[t-5]} || out_tag_w[1] !== 4'(t + 3)) begin
          n_err++;
          $display("FAIL b2b_data op%0d: got %h/%h, want %h/%h", t - 5, out_c_w[1], out_tag_w[1], exp[t-5], 4'(t + 3));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] qc[$];
    logic [3:0]  qt[$];
    logic [63:0] hc, ec;
    int acc = 0, got = 0;
    out_ready_w[1] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (acc < 7) put(1, 1'b1, 64'h9ABC0F00 + 64'(acc * 37), acc + 1, 3'(acc % 5), 4'(acc));
      else         put(1, 1'b0, 64'h0, 0, 3'd0, 4'h0);
      @(negedge clk);
      if (t == 5) begin
        hc = out_c_w[1];
        n_cmp++;
        if (out_valid_w[1] !== 1'b1 || in_ready_w[1] !== 1'b0) begin
          n_err++;
          $display("FAIL bp_full: out_valid=%b in_ready=%b, want 1/0", out_valid_w[1], in_ready_w[1]);
        end
      end
      if (t > 5) begin
        n_cmp++;
        if (out_c_w[1] !== hc) begin
          n_err++;
          $display("FAIL bp_hold cycle %0d: out_c=%h, want %h", t, out_c_w[1], hc);
        end
      end
      if (in_valid_w[1] && in_ready_w[1]) begin
        qc.push_back(model(in_a_w[1], int'(in_b_w[1]), in_op_w[1], 32));
        qt.push_back(in_tag_w[1]);
        acc++;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (acc != 5) begin
      n_err++;
      $display("FAIL bp_accepted: %0d ops taken, want 5", acc);
    end
    put(1, 1'b0, 64'h0, 0, 3'd0, 4'h0);
    out_ready_w[1] = 1'b1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (out_valid_w[1] === 1'b1) begin
        n_cmp++;
        if (qc.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra: unexpected result %h", out_c_w[1]);
        end else begin
          ec = qc.pop_front();
          if (out_c_w[1] !== ec || out_tag_w[1] !== qt.pop_front()) begin
            n_err++;
            $display("FAIL bp_order result %0d: got %h, want %h", got, out_c_w[1], ec);
          end
          got++;
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got != 5 || in_ready_w[1] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drain: %0d results in_ready=%b, want 5/1", got, in_ready_w[1]);
    end
  endtask

  task automatic test_passthrough;
    for (int t = 0; t < 8; t++) begin
      if (t == 0)      put(1, 1'b1, 64'hDEADBEEF, 13, 3'b111, 4'h5);
      else if (t == 1) put(1, 1'b1, 64'hDEADBEEF, 0, 3'b000, 4'h6);
      else             put(1, 1'b0, 64'h0, 0, 3'd0, 4'h0);
      @(negedge clk);
      n_cmp++;
      if (out_valid_w[1] !== (t == 5 || t == 6)) begin
        n_err++;
        $display("FAIL pass_valid cycle %0d: out_valid=%b", t, out_valid_w[1]);
      end
      if ((t == 5 || t == 6) && out_valid_w[1] === 1'b1) begin
        n_cmp++;
        if (out_c_w[1] !== 64'hDEADBEEF || out_tag_w[1] !== 4'(t)) begin
          n_err++;
          $display("FAIL pass_data cycle %0d: got %h/%h, want deadbeef/%h", t, out_c_w[1], out_tag_w[1], 4'(t));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_flush;
    for (int t = 0; t < 14; t++) begin
      rst = (t == 3);
      if (t <= 3)      put(1, 1'b1, 64'(t + 1), t + 1, 3'd0, 4'(t + 1));
      else if (t == 4) put(1, 1'b1, 64'hA5, 3, 3'd0, 4'h9);
      else             put(1, 1'b0, 64'h0, 0, 3'd0, 4'h0);
      @(negedge clk);
      if (t == 3) begin
        n_cmp++;
        if (in_ready_w[1] !== 1'b1) begin
          n_err++;
          $display("FAIL flush_ready_in_rst: in_ready=%b, want 1", in_ready_w[1]);
        end
      end
      if (t >= 4) begin
        n_cmp++;
        if (out_valid_w[1] !== (t == 9)) begin
          n_err++;
          $display("FAIL flush_valid cycle %0d: out_valid=%b, want %b", t, out_valid_w[1], (t == 9));
        end
      end
      if (t == 9 && out_valid_w[1] === 1'b1) begin
        n_cmp++;
        if (out_c_w[1] !== 64'h528 || out_tag_w[1] !== 4'h9) begin
          n_err++;
          $display("FAIL flush_newop: got %h/%h, want 528/9", out_c_w[1], out_tag_w[1]);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_random(input int i, input int n);
    logic [63:0] qc[$];
    logic [3:0]  qt[$];
    logic [63:0] mask, hc, ec;
    logic [3:0]  ht, et;
    logic        hold = 1'b0;
    int w = wid(i);
    int sent = 0, slots = 0;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    while ((sent < n || qc.size() != 0) && slots < n * 8 + 200) begin
      put(i, (sent < n) && ($urandom_range(3) != 0), {$urandom, $urandom} & mask,
          int'($urandom_range(w - 1)), 3'($urandom_range(7)), 4'($urandom));
      out_ready_w[i] = (sent >= n) || ($urandom_range(2) != 0);
      @(negedge clk);
      if (hold) begin
        n_cmp++;
        if (out_valid_w[i] !== 1'b1 || out_c_w[i] !== hc || out_tag_w[i] !== ht) begin
          n_err++;
          $display("FAIL rand_hold w%0d: got %b/%h/%h, want 1/%h/%h", w, out_valid_w[i], out_c_w[i], out_tag_w[i], hc, ht);
        end
      end
      hold = out_valid_w[i] && !out_ready_w[i];
      hc = out_c_w[i];
      ht = out_tag_w[i];
      if (out_valid_w[i] && out_ready_w[i]) begin
        n_cmp++;
        if (qc.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra w%0d: unexpected result %h", w, out_c_w[i]);
        end else begin
          ec = qc.pop_front();
          et = qt.pop_front();
          if (out_c_w[i] !== ec || out_tag_w[i] !== et) begin
            n_err++;
            $display("FAIL rand_data w%0d: got %h/%h, want %h/%h", w, out_c_w[i], out_tag_w[i], ec, et);
          end
        end
      end
      if (in_valid_w[i] && in_ready_w[i]) begin
        qc.push_back(model(in_a_w[i], int'(in_b_w[i]), in_op_w[i], w));
        qt.push_back(in_tag_w[i]);
        sent++;
      end
      @(posedge clk); #1;
      slots++;
    end
    n_cmp++;
    if (sent != n || qc.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain w%0d: sent %0d of %0d, %0d pending", w, sent, n, qc.size());
    end
    put(i, 1'b0, 64'h0, 0, 3'd0, 4'h0);
    out_ready_w[i] = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(i, 1'b0, 64'h0, 0, 3'd0, 4'h0);
      out_ready_w[i] = 1'b1;
    end
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_passthrough;
    test_reset_flush;
    test_random(0, 300);
    test_random(1, 300);
    test_random(2, 300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 The block SHALL derive localparam SH_W = log2(WIDTH), which is both the shift-amount width and the number of pipeline stages.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  an operation is offered on the in_* ports.
REQ-007 in_ready  output  1  the block accepts the offered operation this cycle.
REQ-008 in_a  input  WIDTH  operand.
REQ-009 in_b  input  SH_W  shift amount, unsigned.
REQ-010 in_op  input  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through.
REQ-011 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-012 out_valid  output  1  a result is presented on out_c / out_tag.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_c  output  WIDTH  result.
REQ-015 out_tag  output  TAG_W  tag of the result.

Function
REQ-016 An operation SHALL be accepted on a cycle with in_valid && in_ready; a result SHALL be consumed on a cycle with out_valid && out_ready.
REQ-017 The pipeline SHALL have SH_W register stages; stage k (k = 0..SH_W-1) SHALL apply a shift of 2^k positions when bit k of the carried shift amount is 1, and pass data through otherwise.
REQ-018 Internal enable: advance = !out_valid || out_ready; when advance is 1 all stages SHALL shift forward one position, and when it is 0 all stage registers SHALL hold.
REQ-019 in_ready SHALL equal advance (combinational from out_valid and out_ready only, never from in_valid).
REQ-020 Latency SHALL be exactly SH_W cycles from acceptance to out_valid when out_ready stays high; throughput SHALL be one operation per cycle.
REQ-021 Each stage SHALL carry a valid bit; a bubble (in_valid = 0 while advance = 1) SHALL propagate as valid = 0 and SHALL not be collapsed.
REQ-022 Per stage, the valid bit, data, remaining shift bits, op and tag SHALL move together, and results SHALL emerge in acceptance order.
REQ-023 SLL SHALL zero-fill from the LSB.
REQ-024 SRL SHALL zero-fill from the MSB.
REQ-025 SRA SHALL replicate the original in_a[WIDTH-1] into vacated MSBs.
REQ-026 ROL and ROR SHALL rotate with no bit loss.
REQ-027 Pass-through ops SHALL return in_a unchanged regardless of in_b.
REQ-028 in_b = 0 SHALL return in_a for every op; the maximum shift is WIDTH-1 and no out-of-range amount exists.
REQ-029 out_c and out_tag SHALL hold stable while out_valid && !out_ready.
REQ-030 out_c and out_tag SHALL be don't-care when out_valid = 0; they are only checked when out_valid = 1.
REQ-031 No combinational path SHALL exist from in_* to out_*.

Reset
REQ-032 On rst = 1 at a clock edge, all stage valid bits SHALL clear and out_valid SHALL read 0 on the following cycle; data, tag and op registers MAY remain uncleared.
REQ-033 rst SHALL take priority over advance, and any operations in flight at reset SHALL be discarded and never appear at the output.
REQ-034 During rst, in_ready SHALL follow REQ-019; an operation accepted in the same cycle as rst = 1 SHALL be discarded.

Verification (WIDTH=32, TAG_W=4, SH_W=5)
REQ-035 SLL 0x00000001 by 31, tag 0x3, out_ready = 1 -> out_valid exactly 5 cycles later, out_c = 0x80000000, out_tag = 0x3.
REQ-036 Back-to-back ops, one per cycle, then a bubble -> SRA 0x80000000 by 4 = 0xF8000000; SRL 0x80000000 by 4 = 0x08000000; ROR 0x000000F1 by 4 = 0x1000000F; ROL 0xF0000001 by 4 = 0x0000001F; results appear on consecutive cycles, followed by one cycle with out_valid = 0.
REQ-037 Hold out_ready = 0 and offer 7 ops -> exactly 5 ops are accepted, then in_ready = 0 and out_c is stable; raise out_ready -> all 5 results appear in order with no loss or duplication, and in_ready = 1 again.
REQ-038 Op 111 on 0xDEADBEEF by 13, and SLL on 0xDEADBEEF by 0 -> both return 0xDEADBEEF.
REQ-039 Assert rst for 1 cycle with 3 ops in flight -> out_valid = 0 on the next cycle and none of the 3 results ever appears; a new op issued after reset returns its correct result after 5 cycles.
REQ-040 Random ops, amounts, tags and out_ready patterns at WIDTH = 8, 32 and 64 -> results match a reference-model scoreboard in acceptance order.
